dpi_call_arbiter: RTL and testbench

//  Shares one DPI-C call channel between NREQ requesters. Each requester hands over one
//  int argument; the winner goes to the C-side shim (which calls the imported function)
//  and the shim's return value or timeout status is routed back to that requester.

---
 rtl/dpi_call_arbiter.sv | 131 +++++++++++++
 tb/tb_dpi_call_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpi_call_arbiter.sv
// Round-robin arbiter that shares a single DPI-C call channel between NREQ
// requesters. The winner's argument is presented to the C-side shim; the shim's
// return value (or a timeout indication) is routed back to that requester.
//
// Handshake rules (valid/ready, all transfers on the rising edge of clk):
//   req:  req_valid[i] is held with a stable req_arg slice until req_ready[i]
//         pulses for one cycle; that cycle is the accept.
//   call: call_valid/call_arg are held stable until call_ready is seen high.
//   ret:  ret_valid is a strobe, only honoured while waiting for the return.
//   rsp:  rsp_valid is a one-cycle, one-hot strobe with no ready; rsp_data and
//         rsp_err are meaningful only alongside it and read 0 otherwise.
module dpi_call_arbiter #(
    parameter int NREQ    = 4,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*DW-1:0]   req_arg,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [DW-1:0]        rsp_data,
    output logic                 rsp_err,
    output logic                 call_valid,
    output logic [DW-1:0]        call_arg,
    input  logic                 call_ready,
    input  logic                 ret_valid,
    input  logic [DW-1:0]        ret_data,
    output logic                 busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t          r_state;
    logic [IW-1:0]   r_grant;
    logic [IW-1:0]   r_rr_ptr;
    logic [DW-1:0]   r_arg;
    logic [DW-1:0]   r_data;
    logic            r_err;
    logic [TW-1:0]   r_timer;

    logic            w_found;
    logic [IW-1:0]   w_pick;
    logic [IW-1:0]   w_cand;

    // Round-robin search: first pending requester after the last one served, with wrap.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_cand  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_cand = IW'((int'(r_rr_ptr) + k) % NREQ);
            if (!w_found && req_valid[w_cand]) begin
                w_found = 1'b1;
                w_pick  = w_cand;
            end
        end
    end

    // Accept is combinational so the requester sees it in the same IDLE cycle;
    // it is held low while reset is asserted so every output reads 0 in reset.
    assign req_ready = (!reset && r_state == S_IDLE && w_found) ? (NREQ'(1) << w_pick) : '0;

    // Everything else is decoded from registered state only.
    assign call_valid = (r_state == S_ISSUE);
    assign call_arg   = r_arg;
    assign rsp_valid  = (r_state == S_RESP) ? (NREQ'(1) << r_grant) : '0;
    assign rsp_data   = (r_state == S_RESP) ? r_data : '0;
    assign rsp_err    = (r_state == S_RESP) ? r_err  : 1'b0;
    assign busy       = (r_state != S_IDLE);

    // Call sequencer: accept -> present to shim -> wait for return/timeout -> respond.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_grant  <= '0;
            r_rr_ptr <= IW'(NREQ - 1);
            r_arg    <= '0;
            r_data   <= '0;
            r_err    <= 1'b0;
            r_timer  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant <= w_pick;
                        r_arg   <= req_arg[int'(w_pick)*DW +: DW];
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // No timeout here: the shim is trusted to accept eventually.
                    if (call_ready) begin
                        r_timer <= '0;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_timer <= r_timer + TW'(1);
                    // A return landing in the final cycle beats the timeout.
                    if (ret_valid) begin
                        r_data  <= ret_data;
                        r_err   <= 1'b0;
                        r_state <= S_RESP;
                    end else if (r_timer == T_LAST) begin
                        r_data  <= '0;
                        r_err   <= 1'b1;
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    // The requester just served becomes lowest priority next time.
                    r_rr_ptr <= r_grant;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dpi_call_arbiter.sv
// Bench for dpi_call_arbiter: directed scenarios followed by randomized rounds.
// The driver pushes each expected response (grant, data, err, cycle) into a
// queue; an independent monitor pops and compares whenever rsp_valid fires.
module tb_dpi_call_arbiter;

    localparam int NREQ    = 4;
    localparam int DW      = 32;
    localparam int TIMEOUT = 8;
    localparam int QW      = 16 + NREQ + 1 + DW;

    // ---------------- clock / reset ----------------
    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*DW-1:0]  req_arg;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ-1:0]     rsp_valid;
    logic [DW-1:0]       rsp_data;
    logic                rsp_err;
    logic                call_valid;
    logic [DW-1:0]       call_arg;
    logic                call_ready;
    logic                ret_valid;
    logic [DW-1:0]       ret_data;
    logic                busy;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    dpi_call_arbiter #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_arg    (req_arg),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .call_valid (call_valid),
        .call_arg   (call_arg),
        .call_ready (call_ready),
        .ret_valid  (ret_valid),
        .ret_data   (ret_data),
        .busy       (busy)
    );

    // ---------------- scoreboard state ----------------
    logic [QW-1:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int m_last = NREQ - 1;   // requester served most recently (reference model)

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference rule: serve the first pending requester after the last one served.
    function automatic int pick();
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (m_last + k) % NREQ;
            if (req_valid[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_ready"},  64'(req_ready),  64'(0));
        chk({tag, "_rsp_valid"},  64'(rsp_valid),  64'(0));
        chk({tag, "_rsp_data"},   64'(rsp_data),   64'(0));
        chk({tag, "_rsp_err"},    64'(rsp_err),    64'(0));
        chk({tag, "_call_valid"}, 64'(call_valid), 64'(0));
        chk({tag, "_call_arg"},   64'(call_arg),   64'(0));
        chk({tag, "_busy"},       64'(busy),       64'(0));
    endtask

    // ---------------- driver tasks ----------------
    // Entered and left at a falling edge with the DUT idle.
    task automatic do_reset();
        reset = 1'b1;
        req_valid = '1;
        for (int i = 0; i < NREQ; i++) req_arg[i*DW +: DW] = $urandom;
        call_ready = 1'b1;
        ret_valid  = 1'b1;
        ret_data   = $urandom;
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        m_last = NREQ - 1;
        req_valid  = '0;
        call_ready = 1'b0;
        ret_valid  = 1'b0;
        reset      = 1'b0;
    endtask

    // One arbitration round. raise/drop edit the pending set first; the shim
    // accepts after rdelay stalled cycles and returns on WAIT cycle k (never if
    // k >= TIMEOUT). abort_at >= 0 asserts reset in that WAIT cycle instead.
    task automatic do_round(input logic [NREQ-1:0] raise, input logic [NREQ-1:0] drop,
                            input int rdelay, input int k, input int abort_at,
                            input logic [DW-1:0] rdata, input bit reraise);
        int w;
        logic [NREQ-1:0] oh;
        logic [DW-1:0] exp_arg;
        logic [DW-1:0] data;
        logic err;
        for (int i = 0; i < NREQ; i++) begin
            if (raise[i] && !req_valid[i]) begin
                req_valid[i] = 1'b1;
                req_arg[i*DW +: DW] = $urandom;
            end
        end
        req_valid  = req_valid & ~drop;
        call_ready = 1'($urandom_range(0, 1));
        ret_valid  = 1'($urandom_range(0, 1));   // stray return while idle
        ret_data   = $urandom;
        #1;
        w  = pick();
        oh = '0;
        if (w >= 0) oh[w] = 1'b1;
        chk("idle_busy", 64'(busy), 64'(0));
        chk("req_ready", 64'(req_ready), 64'(oh));
        if (w < 0) begin
            @(negedge clk);
            return;
        end
        exp_arg = req_arg[w*DW +: DW];
        @(negedge clk);
        req_valid[w] = 1'b0;
        m_last = w;
        for (int d = 0; d <= rdelay; d++) begin
            call_ready = (d == rdelay);
            ret_valid  = 1'($urandom_range(0, 1));   // must be ignored before WAIT
            ret_data   = $urandom;
            #1;
            chk("issue_valid", 64'(call_valid), 64'(1));
            chk("issue_arg", 64'(call_arg), 64'(exp_arg));
            chk("issue_no_ready", 64'(req_ready), 64'(0));
            @(negedge clk);
        end
        call_ready = 1'b0;
        for (int j = 0; j < TIMEOUT; j++) begin
            ret_valid = (j == k);
            ret_data  = (j == k) ? rdata : DW'($urandom);
            #1;
            chk("wait_busy", 64'(busy), 64'(1));
            chk("wait_no_call", 64'(call_valid), 64'(0));
            chk("wait_no_ready", 64'(req_ready), 64'(0));
            if (j == abort_at) begin
                ret_valid = 1'b0;
                #1;
                reset = 1'b1;
                #1;
                chk_all_zero("midreset");
                m_last = NREQ - 1;
                @(negedge clk);
                @(negedge clk);
                reset = 1'b0;
                return;
            end
            if (j == k || j == TIMEOUT - 1) begin
                err  = (j != k);
                data = err ? '0 : rdata;
                exp_q.push_back({16'(cyc + 1), oh, err, data});
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        // Response cycle: stray return and optional re-raise by the served requester.
        ret_valid  = 1'($urandom_range(0, 1));
        ret_data   = $urandom;
        call_ready = 1'($urandom_range(0, 1));
        if (reraise) begin
            req_valid[w] = 1'b1;
            req_arg[w*DW +: DW] = $urandom;
        end
        #1;
        chk("resp_no_ready", 64'(req_ready), 64'(0));
        @(negedge clk);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [QW-1:0] e;
        if (!reset) begin
            if (rsp_valid != '0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 64'(rsp_valid), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_grant", 64'(rsp_valid), 64'(e[DW+NREQ:DW+1]));
                    chk("rsp_data", 64'(rsp_data), 64'(e[DW-1:0]));
                    chk("rsp_err", 64'(rsp_err), 64'(e[DW]));
                    chk("rsp_cycle", 64'(cyc[15:0]), 64'(e[QW-1:QW-16]));
                end
            end else begin
                chk("rsp_idle_data", 64'(rsp_data), 64'(0));
                chk("rsp_idle_err", 64'(rsp_err), 64'(0));
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        req_valid  = '0;
        req_arg    = '0;
        call_ready = 1'b0;
        ret_valid  = 1'b0;
        ret_data   = '0;
        @(negedge clk);
        do_reset();

        // Single call from requester 1, minimum latency.
        req_valid[1] = 1'b1;
        req_arg[1*DW +: DW] = 32'd10;
        do_round('0, '0, 0, 0, -1, 32'd10, 1'b0);

        // All four held after reset: grants 0,1,2,3,0.
        @(negedge clk);
        do_reset();
        for (int r = 0; r < 5; r++) do_round(4'b1111, '0, 0, 1, -1, $urandom, 1'b1);

        // Timeout, then idle cycles with stray returns.
        do_round(4'b0100, 4'b1011, 1, 1000, -1, '0, 1'b0);
        for (int r = 0; r < 3; r++) do_round('0, '1, 0, 0, -1, '0, 1'b0);

        // Return in the exact timeout cycle wins.
        do_round(4'b1000, 4'b0111, 0, TIMEOUT - 1, -1, 32'hCAFE, 1'b0);

        // Shim stalls 5 cycles with other requesters pending.
        do_round(4'b1111, '0, 5, 2, -1, $urandom, 1'b0);

        // Reset in WAIT drops the call; requester 0 then wins first.
        do_round(4'b0110, 4'b1001, 0, 100, 3, '0, 1'b0);
        do_round(4'b1001, '0, 0, 0, -1, $urandom, 1'b0);

        // Randomized rounds.
        for (int r = 0; r < 80; r++) begin
            logic [NREQ-1:0] rs;
            logic [NREQ-1:0] dr;
            int kk;
            rs = NREQ'($urandom_range(0, 15));
            dr = ($urandom_range(0, 3) == 0) ? NREQ'($urandom_range(0, 15)) : '0;
            kk = ($urandom_range(0, 4) == 0) ? TIMEOUT - 1 : int'($urandom_range(0, TIMEOUT + 2));
            do_round(rs, dr, int'($urandom_range(0, 4)), kk, -1, $urandom,
                     1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        chk("queue_empty", 64'(exp_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
